// File: rtl/ibex_wb_arb_pkg.sv
// Shared types and helpers for the Wishbone host arbiter.
// Feature macro used by the top: IBEX_WB_TIMEOUT_EN (optional transfer timeout).
package ibex_wb_arb_pkg;

    localparam int unsigned WbAddrWidth = 32;
    localparam int unsigned WbDataWidth = 32;
    localparam int unsigned WbBeWidth   = WbDataWidth / 8;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbStb,
        ArbWait
    } arb_state_e;

    typedef struct packed {
        logic [WbAddrWidth-1:0] addr;
        logic                   we;
        logic [WbBeWidth-1:0]   be;
        logic [WbDataWidth-1:0] wdata;
    } wb_req_t;

    // Index width that stays legal for a single host.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ibex_wb_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping, returned both one-hot and as an index.
module ibex_wb_rr_pick
    import ibex_wb_arb_pkg::*;
#(
    parameter  int unsigned NrHosts = 2,
    localparam int unsigned IdxW    = idx_width(NrHosts)
) (
    input  logic [NrHosts-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic               valid_o,
    output logic [NrHosts-1:0] onehot_o,
    output logic [IdxW-1:0]    idx_o
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NrHosts; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NrHosts) begin
                cand = cand - NrHosts;
            end
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o            = 1'b1;
                onehot_o[cand_idx] = 1'b1;
                idx_o              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ibex_wb_host_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone master between req/gnt/rvalid hosts,
// one outstanding transfer at a time. Define IBEX_WB_TIMEOUT_EN for a forced-error timeout.
module ibex_wb_host_arbiter
    import ibex_wb_arb_pkg::*;
#(
    parameter int unsigned NrHosts       = 2,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic [NrHosts-1:0]      host_req_i,
    output logic [NrHosts-1:0]      host_gnt_o,
    input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]      host_we_i,
    input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]      host_rvalid_o,
    output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]      host_err_o,

    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [AddressWidth-1:0] wb_addr_o,
    output logic [DataWidth-1:0]    wb_data_o,
    output logic [DataWidth/8-1:0]  wb_sel_o,
    input  logic                    wb_stall_i,
    input  logic                    wb_ack_i,
    input  logic [DataWidth-1:0]    wb_data_i,
    input  logic                    wb_err_i
);

    localparam int unsigned     IdxW    = idx_width(NrHosts);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NrHosts - 1);

    arb_state_e         state_q, state_d;
    wb_req_t            req_q;
    logic [IdxW-1:0]    owner_q;
    logic [IdxW-1:0]    ptr_q;
    logic [NrHosts-1:0] rvalid_q;
    logic [DataWidth-1:0] rdata_q;
    logic               err_q;

    logic               pick_valid;
    logic [NrHosts-1:0] pick_onehot;
    logic [IdxW-1:0]    pick_idx;

    logic grant;
    logic complete;
    logic timed_out;
    logic tmo_hit;

    ibex_wb_rr_pick #(
        .NrHosts (NrHosts)
    ) u_rr_pick (
        .req_i    (host_req_i),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ArbIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        complete  = 1'b0;
        timed_out = 1'b0;
        unique case (state_q)
            ArbIdle: begin
                if (pick_valid) begin
                    grant   = 1'b1;
                    state_d = ArbStb;
                end
            end
            ArbStb: begin
                // A response on the accepting cycle finishes the transfer without visiting ArbWait.
                if (!wb_stall_i) begin
                    if (wb_ack_i || wb_err_i) begin
                        complete = 1'b1;
                        state_d  = ArbIdle;
                    end else begin
                        state_d = ArbWait;
                    end
                end
            end
            ArbWait: begin
                if (wb_ack_i || wb_err_i) begin
                    complete = 1'b1;
                    state_d  = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
        if (tmo_hit && !complete) begin
            complete  = 1'b1;
            timed_out = 1'b1;
            state_d   = ArbIdle;
        end
    end

`ifdef IBEX_WB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

    logic [TmoW-1:0] tmo_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (grant) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ArbIdle) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Fires on the cycle whose increment would reach TimeoutCycles.
    assign tmo_hit = (state_q != ArbIdle) && (tmo_cnt_q == TmoW'(TimeoutCycles - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else if (grant) begin
            req_q.addr  <= WbAddrWidth'(host_addr_i[pick_idx]);
            req_q.we    <= host_we_i[pick_idx];
            req_q.be    <= WbBeWidth'(host_be_i[pick_idx]);
            req_q.wdata <= WbDataWidth'(host_wdata_i[pick_idx]);
            owner_q     <= pick_idx;
            ptr_q       <= (pick_idx == LastIdx) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            if (complete) begin
                rvalid_q[owner_q] <= 1'b1;
                if (timed_out || wb_err_i) begin
                    err_q <= 1'b1;
                end else begin
                    rdata_q <= wb_data_i;
                end
            end
        end
    end

    assign host_gnt_o    = grant ? pick_onehot : '0;
    assign host_rvalid_o = rvalid_q;

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = rvalid_q[h] ? rdata_q : '0;
            host_err_o[h]   = rvalid_q[h] & err_q;
        end
    end

    assign wb_cyc_o  = (state_q != ArbIdle);
    assign wb_stb_o  = (state_q == ArbStb);
    assign wb_we_o   = req_q.we;
    assign wb_addr_o = AddressWidth'(req_q.addr);
    assign wb_data_o = DataWidth'(req_q.wdata);
    assign wb_sel_o  = (DataWidth/8)'(req_q.be);

endmodule
